icache_direct: RTL and testbench

Direct-mapped, read-only instruction cache between the datapath's instruction-fetch port (icache side of the datapath/cache interface) and the memory arbiter's instruction port. It answers fetches combinationally on a hit. On a miss it runs a single-word fill from memory, and supports a one-cycle whole-cache invalidate.

---
 rtl/icache_direct.sv | 150 +++++++++++++++
 tb/tb_icache_direct.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache with single-word miss fill.
// Define ICACHE_PERF_EN to build the saturating hit_count / miss_count counters.
module icache_direct #(
   parameter int unsigned SETS = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   input  logic        iflush,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic [31:0] iload,
   input  logic        iwait
`ifdef ICACHE_PERF_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int unsigned IDXW = $clog2(SETS);
   localparam int unsigned TAGW = 32 - IDXW - 2;
   localparam int unsigned WADW = 30;

   typedef enum logic {
      S_IDLE,
      S_FETCH
   } state_e;

   state_e          state_q, state_d;
   logic [WADW-1:0] miss_addr_q, miss_addr_d;
   logic [SETS-1:0] valid_q, valid_d;
   logic [TAGW-1:0] tag_q  [SETS];
   logic [31:0]     data_q [SETS];

   logic [IDXW-1:0] req_idx;
   logic [TAGW-1:0] req_tag;
   logic [IDXW-1:0] fill_idx;
   logic [TAGW-1:0] fill_tag;
   logic            hit_c;
   logic            fill_c;
   logic            unused_byte_sel;

   // Byte offset plays no part in a word-granular cache.
   assign unused_byte_sel = ^imemaddr[1:0];

   assign req_idx  = imemaddr[IDXW+1:2];
   assign req_tag  = imemaddr[31:IDXW+2];
   assign fill_idx = miss_addr_q[IDXW-1:0];
   assign fill_tag = miss_addr_q[WADW-1:IDXW];

   assign hit_c  = imemREN & valid_q[req_idx] & (tag_q[req_idx] == req_tag)
                   & (state_q == S_IDLE);
   assign fill_c = (state_q == S_FETCH) & ~iwait;

   // State, miss address and valid bits; reset abandons any fill in progress.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= S_IDLE;
         miss_addr_q <= '0;
         valid_q     <= '0;
      end else begin
         state_q     <= state_d;
         miss_addr_q <= miss_addr_d;
         valid_q     <= valid_d;
      end
   end

   // Tag and data arrays carry no reset; valid bits qualify them.
   always_ff @(posedge CLK) begin
      if (fill_c) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= iload;
      end
   end

   always_comb begin
      state_d     = state_q;
      miss_addr_d = miss_addr_q;
      valid_d     = valid_q;
      case (state_q)
         S_IDLE: begin
            if (imemREN && !hit_c) begin
               state_d     = S_FETCH;
               miss_addr_d = imemaddr[31:2];
            end
         end
         S_FETCH: begin
            if (!iwait) begin
               state_d           = S_IDLE;
               valid_d[fill_idx] = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Flush wins over a fill landing on the same edge: data written, frame left invalid.
      if (iflush) begin
         valid_d = '0;
      end
   end

   always_comb begin
      ihit     = 1'b0;
      imemload = '0;
      iREN     = 1'b0;
      iaddr    = '0;
      if (hit_c) begin
         ihit     = 1'b1;
         imemload = data_q[req_idx];
      end
      if (state_q == S_FETCH) begin
         iREN  = 1'b1;
         iaddr = {miss_addr_q, 2'b00};
      end
   end

`ifdef ICACHE_PERF_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   // Saturating counters, cleared by reset only.
   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (hit_c && (hit_cnt_q != 32'hFFFF_FFFF)) begin
         hit_cnt_d = hit_cnt_q + 32'd1;
      end
      if ((state_q == S_IDLE) && (state_d == S_FETCH) && (miss_cnt_q != 32'hFFFF_FFFF)) begin
         miss_cnt_d = miss_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios plus randomized traffic
// checked against a word-address reference model of a direct-mapped cache.
module tb_icache_direct;

   localparam int unsigned SETS = 16;

   logic        CLK = 1'b0;
   logic        RST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        iflush;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic [31:0] iload;
   logic        iwait;
`ifdef ICACHE_PERF_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   int unsigned vectors = 0;
   int unsigned errors  = 0;

   logic [31:0] flush_addrs [4];

   // Reference model: per set, which word address is resident and whether it is valid.
   logic        m_valid [SETS];
   logic [31:0] m_word  [SETS];
   logic [31:0] m_data  [SETS];
   logic        m_busy;
   logic [31:0] m_miss;
   int unsigned m_hits;
   int unsigned m_misses;

   icache_direct #(.SETS(SETS)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .imemREN  (imemREN),
      .imemaddr (imemaddr),
      .iflush   (iflush),
      .ihit     (ihit),
      .imemload (imemload),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iload    (iload),
      .iwait    (iwait)
`ifdef ICACHE_PERF_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ((a >> 2) * 32'h9E37_79B1) ^ 32'h2008_0001;
   endfunction

   // Drives a miss on addr and completes its fill; ends at a negedge back in IDLE.
   task automatic do_fill(input logic [31:0] addr, input logic [31:0] data, input int waits);
      imemREN  = 1'b1;
      imemaddr = addr;
      iwait    = 1'b0;
      iflush   = 1'b0;
      @(negedge CLK);
      iwait = 1'b1;
      repeat (waits) @(negedge CLK);
      iwait = 1'b0;
      iload = data;
      @(negedge CLK);
   endtask

   task automatic test_reset();
      RST = 1'b1; imemREN = 1'b0; imemaddr = '0; iflush = 1'b0; iwait = 1'b0; iload = '0;
      @(negedge CLK); #1;
      vectors++; if (ihit !== 1'b0) begin errors++; $display("FAIL reset_ihit got=%0h want=0", ihit); end
      vectors++; if (imemload !== 32'h0) begin errors++; $display("FAIL reset_imemload got=%h want=0", imemload); end
      vectors++; if (iREN !== 1'b0) begin errors++; $display("FAIL reset_iREN got=%0h want=0", iREN); end
      vectors++; if (iaddr !== 32'h0) begin errors++; $display("FAIL reset_iaddr got=%h want=0", iaddr); end
`ifdef ICACHE_PERF_EN
      vectors++; if (hit_count !== 32'h0) begin errors++; $display("FAIL reset_hit_count got=%0d want=0", hit_count); end
      vectors++; if (miss_count !== 32'h0) begin errors++; $display("FAIL reset_miss_count got=%0d want=0", miss_count); end
`endif
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_first_miss();
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = 32'h0000_0040; iwait = 1'b0; iload = '0;
      #1;
      vectors++; if (ihit !== 1'b0) begin errors++; $display("FAIL miss0_ihit got=%0h want=0", ihit); end
      vectors++; if (iREN !== 1'b0) begin errors++; $display("FAIL miss0_iREN got=%0h want=0", iREN); end
      @(negedge CLK);
      iload = 32'h2008_0001;
      #1;
      vectors++; if (iREN !== 1'b1) begin errors++; $display("FAIL miss1_iREN got=%0h want=1", iREN); end
      vectors++; if (iaddr !== 32'h40) begin errors++; $display("FAIL miss1_iaddr got=%h want=00000040", iaddr); end
      vectors++; if (ihit !== 1'b0) begin errors++; $display("FAIL miss1_ihit got=%0h want=0", ihit); end
      @(negedge CLK);
      iload = 32'hBAD0_BAD0;
      #1;
      vectors++; if (ihit !== 1'b1) begin errors++; $display("FAIL miss2_ihit got=%0h want=1", ihit); end
      vectors++; if (imemload !== 32'h2008_0001) begin errors++; $display("FAIL miss2_imemload got=%h want=20080001", imemload); end
      vectors++; if (iREN !== 1'b0) begin errors++; $display("FAIL miss2_iREN got=%0h want=0", iREN); end
      vectors++; if (iaddr !== 32'h0) begin errors++; $display("FAIL miss2_iaddr got=%h want=0", iaddr); end
`ifdef ICACHE_PERF_EN
      vectors++; if (miss_count !== 32'd1) begin errors++; $display("FAIL miss2_miss_count got=%0d want=1", miss_count); end
      vectors++; if (hit_count !== 32'd0) begin errors++; $display("FAIL miss2_hit_count got=%0d want=0", hit_count); end
`endif
   endtask

   task automatic test_evict();
      @(negedge CLK);
      imemaddr = 32'h40;
      #1;
      vectors++; if (ihit !== 1'b1) begin errors++; $display("FAIL refetch_ihit got=%0h want=1", ihit); end
      vectors++; if (iREN !== 1'b0) begin errors++; $display("FAIL refetch_iREN got=%0h want=0", iREN); end
      do_fill(32'h80, 32'hDEAD_0080, 0);
      #1;
      vectors++; if (ihit !== 1'b1) begin errors++; $display("FAIL evict_new_ihit got=%0h want=1", ihit); end
      vectors++; if (imemload !== 32'hDEAD_0080) begin errors++; $display("FAIL evict_new_load got=%h want=dead0080", imemload); end
      imemaddr = 32'h40;
      #1;
      vectors++; if (ihit !== 1'b0) begin errors++; $display("FAIL evict_old_ihit got=%0h want=0", ihit); end
      vectors++; if (imemload !== 32'h0) begin errors++; $display("FAIL evict_old_load got=%h want=0", imemload); end
      do_fill(32'h40, 32'h2008_0001, 0);
   endtask

   task automatic test_stall();
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = 32'h0C; iwait = 1'b1;
      #1;
      vectors++; if (ihit !== 1'b0) begin errors++; $display("FAIL stall0_ihit got=%0h want=0", ihit); end
      for (int c = 1; c <= 4; c++) begin
         @(negedge CLK);
         iwait = (c < 4);
         iload = (c < 4) ? 32'hBAD0_0000 : 32'hC0DE_000C;
         #1;
         vectors++; if (iREN !== 1'b1) begin errors++; $display("FAIL stall%0d_iREN got=%0h want=1", c, iREN); end
         vectors++; if (iaddr !== 32'h0C) begin errors++; $display("FAIL stall%0d_iaddr got=%h want=0000000c", c, iaddr); end
         vectors++; if (ihit !== 1'b0) begin errors++; $display("FAIL stall%0d_ihit got=%0h want=0", c, ihit); end
      end
      @(negedge CLK);
      #1;
      vectors++; if (ihit !== 1'b1) begin errors++; $display("FAIL stall5_ihit got=%0h want=1", ihit); end
      vectors++; if (imemload !== 32'hC0DE_000C) begin errors++; $display("FAIL stall5_load got=%h want=c0de000c", imemload); end
      vectors++; if (iREN !== 1'b0) begin errors++; $display("FAIL stall5_iREN got=%0h want=0", iREN); end
   endtask

   task automatic test_branch();
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = 32'h104; iwait = 1'b0;
      #1;
      vectors++; if (ihit !== 1'b0) begin errors++; $display("FAIL br0_ihit got=%0h want=0", ihit); end
      @(negedge CLK);
      imemaddr = 32'h208; iwait = 1'b1;
      #1;
      vectors++; if (iaddr !== 32'h104) begin errors++; $display("FAIL br1_iaddr got=%h want=00000104", iaddr); end
      vectors++; if (ihit !== 1'b0) begin errors++; $display("FAIL br1_ihit got=%0h want=0", ihit); end
      @(negedge CLK);
      iwait = 1'b0; iload = 32'h1111_0104;
      #1;
      vectors++; if (iaddr !== 32'h104) begin errors++; $display("FAIL br2_iaddr got=%h want=00000104", iaddr); end
      @(negedge CLK);
      #1;
      vectors++; if (ihit !== 1'b0) begin errors++; $display("FAIL br3_ihit got=%0h want=0", ihit); end
      vectors++; if (iREN !== 1'b0) begin errors++; $display("FAIL br3_iREN got=%0h want=0", iREN); end
      @(negedge CLK);
      iload = 32'h2222_0208;
      #1;
      vectors++; if (iaddr !== 32'h208) begin errors++; $display("FAIL br4_iaddr got=%h want=00000208", iaddr); end
      @(negedge CLK);
      #1;
      vectors++; if (ihit !== 1'b1) begin errors++; $display("FAIL br5_ihit got=%0h want=1", ihit); end
      vectors++; if (imemload !== 32'h2222_0208) begin errors++; $display("FAIL br5_load got=%h want=22220208", imemload); end
      imemaddr = 32'h104;
      #1;
      vectors++; if (ihit !== 1'b1) begin errors++; $display("FAIL br6_ihit got=%0h want=1", ihit); end
      vectors++; if (imemload !== 32'h1111_0104) begin errors++; $display("FAIL br6_load got=%h want=11110104", imemload); end
   endtask

   task automatic test_flush();
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = 32'h44; iwait = 1'b0; iflush = 1'b0;
      #1;
      vectors++; if (ihit !== 1'b0) begin errors++; $display("FAIL fl0_ihit got=%0h want=0", ihit); end
      @(negedge CLK);
      iflush = 1'b1; iload = 32'h4444_0044;
      #1;
      vectors++; if (iaddr !== 32'h44) begin errors++; $display("FAIL fl1_iaddr got=%h want=00000044", iaddr); end
      @(negedge CLK);
      iflush = 1'b0;
      #1;
      vectors++; if (ihit !== 1'b0) begin errors++; $display("FAIL fl_same_edge_ihit got=%0h want=0", ihit); end
      @(negedge CLK);
      #1;
      vectors++; if (iREN !== 1'b1) begin errors++; $display("FAIL fl_refill_iREN got=%0h want=1", iREN); end
      @(negedge CLK);
      #1;
      vectors++; if (ihit !== 1'b1) begin errors++; $display("FAIL fl_refill_ihit got=%0h want=1", ihit); end
      vectors++; if (imemload !== 32'h4444_0044) begin errors++; $display("FAIL fl_refill_load got=%h want=44440044", imemload); end
      iflush = 1'b1;
      #1;
      vectors++; if (ihit !== 1'b1) begin errors++; $display("FAIL fl_idle_cycle_ihit got=%0h want=1", ihit); end
      @(negedge CLK);
      iflush = 1'b0; iload = '0;
      flush_addrs[0] = 32'h44; flush_addrs[1] = 32'h208; flush_addrs[2] = 32'h0C; flush_addrs[3] = 32'h80;
      for (int i = 0; i < 4; i++) begin
         imemaddr = flush_addrs[i];
         #1;
         vectors++; if (ihit !== 1'b0) begin errors++; $display("FAIL fl_after_%h_ihit got=%0h want=0", flush_addrs[i], ihit); end
         @(negedge CLK);
         @(negedge CLK);
      end
   endtask

   task automatic test_rst_mid_fetch();
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = 32'h0C; iwait = 1'b0;
      #1;
      vectors++; if (ihit !== 1'b1) begin errors++; $display("FAIL rst_pre_ihit got=%0h want=1", ihit); end
      imemaddr = 32'h30;
      #1;
      vectors++; if (ihit !== 1'b0) begin errors++; $display("FAIL rst_miss_ihit got=%0h want=0", ihit); end
      @(negedge CLK);
      iwait = 1'b1;
      #1;
      vectors++; if (iREN !== 1'b1) begin errors++; $display("FAIL rst_fetch_iREN got=%0h want=1", iREN); end
      #2 RST = 1'b1;
      #1;
      vectors++; if (iREN !== 1'b0) begin errors++; $display("FAIL rst_async_iREN got=%0h want=0", iREN); end
      vectors++; if (iaddr !== 32'h0) begin errors++; $display("FAIL rst_async_iaddr got=%h want=0", iaddr); end
`ifdef ICACHE_PERF_EN
      vectors++; if (hit_count !== 32'h0) begin errors++; $display("FAIL rst_hit_count got=%0d want=0", hit_count); end
      vectors++; if (miss_count !== 32'h0) begin errors++; $display("FAIL rst_miss_count got=%0d want=0", miss_count); end
`endif
      @(negedge CLK);
      RST = 1'b0; iwait = 1'b0; imemaddr = 32'h0C;
      #1;
      vectors++; if (ihit !== 1'b0) begin errors++; $display("FAIL rst_after_ihit got=%0h want=0", ihit); end
      vectors++; if (iREN !== 1'b0) begin errors++; $display("FAIL rst_after_iREN got=%0h want=0", iREN); end
   endtask

   task automatic test_random();
      logic [31:0] widx, sidx, e_load, e_addr, tag;
      logic        e_hit, e_ren;
      RST = 1'b1; imemREN = 1'b0; iflush = 1'b0; iwait = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      for (int s = 0; s < int'(SETS); s++) m_valid[s] = 1'b0;
      m_busy = 1'b0; m_miss = '0; m_hits = 0; m_misses = 0;
      for (int n = 0; n < 1500; n++) begin
         @(negedge CLK);
         case ($urandom_range(0, 2))
            0:       tag = 32'h0;
            1:       tag = 32'h1;
            default: tag = 32'h03FF_FFFF;
         endcase
         imemREN  = ($urandom_range(0, 3) != 0);
         imemaddr = (tag << 6) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         iwait    = ($urandom_range(0, 2) == 0);
         iflush   = ($urandom_range(0, 15) == 0);
         #1;
         iload = (iREN && !iwait) ? mem_word(iaddr) : $urandom();
         #1;
         widx = imemaddr >> 2;
         sidx = widx % SETS;
         if (!m_busy) begin
            e_hit  = imemREN && m_valid[sidx] && (m_word[sidx] == widx);
            e_load = e_hit ? m_data[sidx] : 32'h0;
            e_ren  = 1'b0;
            e_addr = 32'h0;
         end else begin
            e_hit  = 1'b0;
            e_load = 32'h0;
            e_ren  = 1'b1;
            e_addr = m_miss << 2;
         end
         vectors++; if (ihit !== e_hit) begin errors++; $display("FAIL rnd%0d_ihit addr=%h got=%0h want=%0h", n, imemaddr, ihit, e_hit); end
         vectors++; if (imemload !== e_load) begin errors++; $display("FAIL rnd%0d_imemload addr=%h got=%h want=%h", n, imemaddr, imemload, e_load); end
         vectors++; if (iREN !== e_ren) begin errors++; $display("FAIL rnd%0d_iREN got=%0h want=%0h", n, iREN, e_ren); end
         vectors++; if (iaddr !== e_addr) begin errors++; $display("FAIL rnd%0d_iaddr got=%h want=%h", n, iaddr, e_addr); end
         if (e_hit) m_hits++;
         if (!m_busy) begin
            if (imemREN && !e_hit) begin
               m_busy = 1'b1;
               m_miss = widx;
               m_misses++;
            end
         end else if (!iwait) begin
            m_word[m_miss % SETS]  = m_miss;
            m_data[m_miss % SETS]  = mem_word(m_miss << 2);
            m_valid[m_miss % SETS] = 1'b1;
            m_busy = 1'b0;
         end
         if (iflush) begin
            for (int s = 0; s < int'(SETS); s++) m_valid[s] = 1'b0;
         end
      end
      @(negedge CLK);
      imemREN = 1'b0; iflush = 1'b0;
      #1;
`ifdef ICACHE_PERF_EN
      vectors++; if (hit_count !== m_hits) begin errors++; $display("FAIL rnd_hit_count got=%0d want=%0d", hit_count, m_hits); end
      vectors++; if (miss_count !== m_misses) begin errors++; $display("FAIL rnd_miss_count got=%0d want=%0d", miss_count, m_misses); end
`endif
   endtask

   initial begin
      RST = 1'b1; imemREN = 1'b0; imemaddr = '0; iflush = 1'b0; iwait = 1'b0; iload = '0;
      test_reset();
      test_first_miss();
      test_evict();
      test_stall();
      test_branch();
      test_flush();
      test_rst_mid_fetch();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
